// File: rtl/pipeline_interlock_if.sv
// Handshake bundle between the ID stage / control decoder and the hazard
// interlock.
//   master: drives the ID instruction fields and receives the interlock results.
//   slave : the interlock itself.
// Signals:
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_we, id_rd : ID instruction
//   stall, bubble, sb_valid                                       : interlock outputs
//   stall_cnt, hazard_cnt : statistics, present only when INTERLOCK_STATS_EN is defined
interface pipeline_interlock_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_we;
    logic [REG_AW-1:0] id_rd;
    logic              stall;
    logic              bubble;
    logic [2:0]        sb_valid;
`ifdef INTERLOCK_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  hazard_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_we, id_rd,
        input  stall, bubble, sb_valid, stall_cnt, hazard_cnt
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_we, id_rd,
        output stall, bubble, sb_valid, stall_cnt, hazard_cnt
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_we, id_rd,
        input  stall, bubble, sb_valid
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_we, id_rd,
        output stall, bubble, sb_valid
    );
`endif
endinterface

// File: rtl/pipeline_interlock.sv
// RAW hazard interlock for the 5-stage MIPS pipeline.
// A 3-entry scoreboard (EX, MEM, WB) shadows the in-flight register writes.
// When an ID source register matches any valid entry, the interlock holds
// PC and ID and injects a zero control word into CTRL1.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : pipeline_interlock_if.slave (ID fields in; stall/bubble/sb_valid out)
// Optional build macro INTERLOCK_STATS_EN adds the saturating stall_cnt and
// hazard_cnt counters. Without it the counters and their logic are absent.
module pipeline_interlock #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_interlock_if.slave  bus
);
    localparam int STAGES = 3;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

    // Index 0 = EX, 1 = MEM, 2 = WB.
    sb_entry_t [STAGES-1:0] sb;
    logic      [STAGES-1:0] hit_rs, hit_rt;
    logic                   hazard;

    for (genvar i = 0; i < STAGES; i++) begin : g_match
        assign hit_rs[i] = sb[i].v && (sb[i].rd == bus.id_rs);
        assign hit_rt[i] = sb[i].v && (sb[i].rd == bus.id_rt);
    end

    // r0 is never tracked, so it never matches. The register file is not
    // write-through, which means a WB-stage hit still stalls.
    assign hazard = bus.id_valid &&
                    ((bus.id_uses_rs && (bus.id_rs != '0) && (|hit_rs)) ||
                     (bus.id_uses_rt && (bus.id_rt != '0) && (|hit_rt)));

    assign bus.stall    = hazard;
    assign bus.bubble   = hazard;
    assign bus.sb_valid = {sb[2].v, sb[1].v, sb[0].v};

    // EX/MEM/WB never freeze. While stalled, a bubble enters EX, so every
    // stall drains out within 3 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            sb[2]    <= sb[1];
            sb[1]    <= sb[0];
            sb[0].v  <= !hazard && bus.id_valid && bus.id_we && (bus.id_rd != '0);
            sb[0].rd <= bus.id_rd;
        end
    end

`ifdef INTERLOCK_STATS_EN
    logic stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q        <= 1'b0;
            bus.stall_cnt  <= '0;
            bus.hazard_cnt <= '0;
        end else begin
            stall_q <= hazard;
            if (hazard && !(&bus.stall_cnt))
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            // Count an episode once, on its first stalled cycle.
            if (hazard && !stall_q && !(&bus.hazard_cnt))
                bus.hazard_cnt <= bus.hazard_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_interlock.sv
module tb_pipeline_interlock;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_interlock_if #(.REG_AW(5), .CNT_W(2)) bus ();

    pipeline_interlock #(.REG_AW(5), .CNT_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_id(input logic v, input logic we, input logic [4:0] rd,
                          input logic urs, input logic [4:0] rs,
                          input logic urt, input logic [4:0] rt);
        bus.id_valid   = v;
        bus.id_we      = we;
        bus.id_rd      = rd;
        bus.id_uses_rs = urs;
        bus.id_rs      = rs;
        bus.id_uses_rt = urt;
        bus.id_rt      = rt;
    endtask

    // The task presents an instruction in ID and counts the stall cycles.
    // It returns 1 ns after the edge at which the instruction issues.
    task automatic issue(input logic v, input logic we, input logic [4:0] rd,
                         input logic urs, input logic [4:0] rs,
                         input logic urt, input logic [4:0] rt,
                         output int stalls);
        set_id(v, we, rd, urs, rs, urt, rt);
        stalls = 0;
        #1;
        while (bus.stall === 1'b1 && stalls < 10) begin
            stalls++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_id(1, 1, 3, 1, 3, 1, 3);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
                bad++; $display("FAIL reset_stall cyc%0d got=%b/%b exp=0/0", c, bus.stall, bus.bubble);
            end
            total++;
            if (bus.sb_valid !== 3'b000) begin
                bad++; $display("FAIL reset_sb cyc%0d got=%b exp=000", c, bus.sb_valid);
            end
        end
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int n;
        drain();
        issue(1, 1, 3, 1, 1, 1, 2, n);   // ADD r3,r1,r2
        total++;
        if (n !== 0) begin bad++; $display("FAIL b2b_add got=%0d exp=0", n); end
        issue(1, 1, 5, 1, 3, 1, 4, n);   // SUB r5,r3,r4
        total++;
        if (n !== 3) begin bad++; $display("FAIL b2b_stalls got=%0d exp=3", n); end
        total++;
        if (bus.sb_valid !== 3'b001) begin
            bad++; $display("FAIL b2b_sub_in_ex got=%b exp=001", bus.sb_valid);
        end
    endtask

    task automatic test_r0();
        int n;
        drain();
        issue(1, 1, 0, 1, 1, 0, 0, n);   // ADDI r0,r1,5
        total++;
        if (n !== 0 || bus.sb_valid !== 3'b000) begin
            bad++; $display("FAIL r0_alloc got=%0d/%b exp=0/000", n, bus.sb_valid);
        end
        issue(1, 1, 6, 1, 0, 1, 0, n);   // ADD r6,r0,r0
        total++;
        if (n !== 0) begin bad++; $display("FAIL r0_read got=%0d exp=0", n); end
    endtask

    task automatic test_distance();
        int n;
        for (int k = 0; k < 4; k++) begin
            drain();
            issue(1, 1, 7, 1, 1, 0, 0, n);
            for (int u = 0; u < k; u++) issue(1, 1, 9, 1, 1, 1, 2, n);
            issue(1, 1, 10, 0, 0, 1, 7, n);
            total++;
            if (n !== 3 - k) begin
                bad++; $display("FAIL distance_k%0d got=%0d exp=%0d", k, n, 3 - k);
            end
        end
    endtask

    task automatic test_multi();
        int n;
        drain();                         // rs and rt both hit the same producer
        issue(1, 1, 3, 0, 0, 0, 0, n);
        issue(1, 0, 0, 0, 0, 0, 0, n);
        issue(1, 1, 8, 1, 3, 1, 3, n);
        total++;
        if (n !== 2) begin bad++; $display("FAIL both_src got=%0d exp=2", n); end
        drain();                         // the youngest match sets the length
        issue(1, 1, 3, 0, 0, 0, 0, n);
        issue(1, 1, 4, 0, 0, 0, 0, n);
        issue(1, 1, 8, 1, 3, 1, 4, n);
        total++;
        if (n !== 3) begin bad++; $display("FAIL youngest got=%0d exp=3", n); end
        drain();                         // a source that is not read does not stall
        issue(1, 1, 3, 0, 0, 0, 0, n);
        issue(1, 1, 8, 0, 3, 0, 3, n);
        total++;
        if (n !== 0) begin bad++; $display("FAIL unused_src got=%0d exp=0", n); end
    endtask

    task automatic test_invalid();
        int n;
        drain();
        issue(1, 1, 3, 0, 0, 0, 0, n);
        issue(0, 1, 3, 1, 3, 1, 3, n);
        total++;
        if (n !== 0) begin bad++; $display("FAIL invalid_stall got=%0d exp=0", n); end
        total++;
        if (bus.sb_valid !== 3'b010) begin
            bad++; $display("FAIL invalid_alloc got=%b exp=010", bus.sb_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        int n;
        drain();
        issue(1, 1, 3, 1, 1, 1, 2, n);
        set_id(1, 1, 5, 1, 3, 1, 4);
        #1;
        total++;
        if (bus.stall !== 1'b1) begin bad++; $display("FAIL mid_stall1 got=%b exp=1", bus.stall); end
        @(posedge clk); #1;
        total++;
        if (bus.stall !== 1'b1) begin bad++; $display("FAIL mid_stall2 got=%b exp=1", bus.stall); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.stall !== 1'b0 || bus.sb_valid !== 3'b000) begin
            bad++; $display("FAIL mid_reset got=%b/%b exp=0/000", bus.stall, bus.sb_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.sb_valid !== 3'b001) begin
            bad++; $display("FAIL mid_reissue got=%b exp=001", bus.sb_valid);
        end
    endtask

`ifdef INTERLOCK_STATS_EN
    task automatic test_stats();
        int n;
        drain();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        total++;
        if (bus.stall_cnt !== 2'd0 || bus.hazard_cnt !== 2'd0) begin
            bad++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", bus.stall_cnt, bus.hazard_cnt);
        end
        for (int r = 1; r <= 2; r++) begin
            issue(1, 1, 3, 1, 1, 1, 2, n);
            issue(1, 1, 5, 1, 3, 1, 4, n);
            total++;
            if (bus.hazard_cnt !== 2'(r) || bus.stall_cnt !== 2'd3) begin
                bad++; $display("FAIL stats_run%0d got=%0d/%0d exp=%0d/3", r, bus.hazard_cnt, bus.stall_cnt, r);
            end
            drain();
        end
    endtask
`endif

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_back_to_back();
        test_r0();
        test_distance();
        test_multi();
        test_invalid();
        test_reset_mid_stall();
`ifdef INTERLOCK_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
